// File: rtl/sub_slice_sequencer_pkg.sv
// Shared constants and state encoding for the serial 32-bit subtract engine.
package sub_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width; never narrower than one bit.
  function automatic int cnt_w(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/sub_slice_sequencer_subtractor8bit.sv
// Existing 8-bit ripple subtract slice: diff = a - b - bin, bout = borrow out.
module subtractor8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] diff,
  output logic       bout
);

  logic [8:0] w_full;

  assign w_full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
  assign diff   = w_full[7:0];
  assign bout   = w_full[8];

endmodule

// File: rtl/sub_slice_sequencer.sv
// 32-bit subtractor that reuses one 8-bit slice over NUM_SLICES cycles,
// carrying the borrow between slices in a register.
module sub_slice_sequencer
  import sub_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = sub_seq_pkg::SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] subtractor_in0,
  input  logic [WIDTH-1:0] subtractor_in1,
  input  logic             borrow_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] subtractor_out,
  output logic             borrow_out,
  output logic             busy
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int CNT_W      = cnt_w(NUM_SLICES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

  if (WIDTH % SLICE_W != 0) begin : g_width_chk
    $error("sub_slice_sequencer: WIDTH must be a multiple of SLICE_W");
  end

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;

  logic [SLICE_W-1:0] w_diff;
  logic               w_bout;

  subtractor8bit u_slice (
    .a    (r_a[SLICE_W-1:0]),
    .b    (r_b[SLICE_W-1:0]),
    .bin  (r_borrow),
    .diff (w_diff),
    .bout (w_bout)
  );

  // Result fills from the MSB end so the last slice lands in the top byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a      <= subtractor_in0;
          r_b      <= subtractor_in1;
          r_borrow <= borrow_in;
          r_cnt    <= '0;
          r_state  <= RUN;
        end
        RUN: begin
          r_res    <= {w_diff, r_res[WIDTH-1:SLICE_W]};
          r_a      <= r_a >> SLICE_W;
          r_b      <= r_b >> SLICE_W;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign out_valid      = (r_state == DONE);
  assign busy           = (r_state == RUN) || (r_state == DONE);
  assign subtractor_out = r_res;
  assign borrow_out     = r_borrow;

endmodule
